// File: rtl/rob_pkg.sv
// Shared reorder-buffer definitions: sizing and the per-entry payload record.
// The issue queue and dispatch logic take their tag width from here as well.
package rob_pkg;

  localparam int DEPTH = 8;
  localparam int TAG_W = $clog2(DEPTH);

  // Payload of one ROB entry. The valid/done flags are held as separate
  // vectors because, unlike the payload, they are reset.
  typedef struct packed {
    logic        regwrite;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [31:0] pc;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / retire bus of the reorder buffer.
// master = pipeline side (dispatch, execute, retire consumer), slave = ROB.
interface reorder_buffer_if
  import rob_pkg::*;
#(
  parameter int TAG_W = rob_pkg::TAG_W
) ();

  logic             flush;

  logic             alloc_valid;
  logic             alloc_regwrite;
  logic [4:0]       alloc_dest;
  logic [31:0]      alloc_pc;
  logic             alloc_ready;
  logic [TAG_W-1:0] alloc_tag;

  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_value;

  logic             commit_valid;
  logic             commit_regwrite;
  logic [4:0]       commit_dest;
  logic [31:0]      commit_value;
  logic [31:0]      commit_pc;

  logic [TAG_W:0]   count;
  logic             full;
  logic             empty;

  modport master (
    output flush,
    output alloc_valid, alloc_regwrite, alloc_dest, alloc_pc,
    input  alloc_ready, alloc_tag,
    output wb_valid, wb_tag, wb_value,
    input  commit_valid, commit_regwrite, commit_dest, commit_value, commit_pc,
    input  count, full, empty
  );

  modport slave (
    input  flush,
    input  alloc_valid, alloc_regwrite, alloc_dest, alloc_pc,
    output alloc_ready, alloc_tag,
    input  wb_valid, wb_tag, wb_value,
    output commit_valid, commit_regwrite, commit_dest, commit_value, commit_pc,
    output count, full, empty
  );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates in program order, accepts out-of-order
// completions, and retires at most one completed head entry per cycle.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = rob_pkg::DEPTH,
  parameter int TAG_W = rob_pkg::TAG_W
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);

  localparam logic [TAG_W-1:0] PTR_ONE  = TAG_W'(1);
  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] done;
  rob_entry_t       entry [DEPTH];

  logic full;
  logic empty;
  logic do_alloc;
  logic do_wb;
  logic do_commit;

  // Decode this cycle's allocate / writeback / retire events from registered state.
  // NOTE: every signal gets a value on every path through an always_comb, otherwise a latch is inferred.
  always_comb begin
    full      = (count == CNT_FULL);
    empty     = (count == '0);
    do_alloc  = bus.alloc_valid && !full;
    do_wb     = bus.wb_valid && valid[bus.wb_tag] && !done[bus.wb_tag];
    do_commit = valid[head] && done[head];
  end

  assign bus.alloc_ready = !full;
  assign bus.alloc_tag   = tail;
  assign bus.count       = count;
  assign bus.full        = full;
  assign bus.empty       = empty;

  // Pointers, occupancy and per-entry valid/done flags.
  // The three events never touch the same flag: alloc is blocked when tail==head
  // with a valid head, and writebacks only land on valid, not-yet-done entries.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (do_commit) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_ONE;
      end
      if (do_alloc) begin
        valid[tail] <= 1'b1;
        done[tail]  <= 1'b0;
        tail        <= tail + PTR_ONE;
      end
      if (do_wb) begin
        done[bus.wb_tag] <= 1'b1;
      end
      case ({do_alloc, do_commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry payload storage; stale contents are harmless once the valid flag is clear.
  // NOTE: the payload array is deliberately not reset -- only the control flags need a known value.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      entry[tail].regwrite <= bus.alloc_regwrite;
      entry[tail].dest     <= bus.alloc_dest;
      entry[tail].pc       <= bus.alloc_pc;
    end
    if (do_wb) begin
      entry[bus.wb_tag].value <= bus.wb_value;
    end
  end

  // Registered retire port: one pulse per retired head entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.commit_valid    <= 1'b0;
      bus.commit_regwrite <= 1'b0;
      bus.commit_dest     <= '0;
      bus.commit_value    <= '0;
      bus.commit_pc       <= '0;
    end else if (bus.flush) begin
      bus.commit_valid <= 1'b0;
    end else begin
      bus.commit_valid <= do_commit;
      if (do_commit) begin
        bus.commit_regwrite <= entry[head].regwrite;
        bus.commit_dest     <= entry[head].dest;
        bus.commit_value    <= entry[head].value;
        bus.commit_pc       <= entry[head].pc;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (DEPTH=8, TAG_W=3).
module tb_reorder_buffer;

  logic clk = 1'b0;
  logic rst;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(3)) bus ();

  reorder_buffer #(.DEPTH(8), .TAG_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs changed 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush          = 1'b0;
    bus.alloc_valid    = 1'b0;
    bus.alloc_regwrite = 1'b0;
    bus.alloc_dest     = '0;
    bus.alloc_pc       = '0;
    bus.wb_valid       = 1'b0;
    bus.wb_tag         = '0;
    bus.wb_value       = '0;
  endtask

  task automatic set_alloc(input logic [31:0] pc, input logic [4:0] dest, input logic rw);
    bus.alloc_valid    = 1'b1;
    bus.alloc_pc       = pc;
    bus.alloc_dest     = dest;
    bus.alloc_regwrite = rw;
  endtask

  task automatic set_wb(input logic [2:0] tag, input logic [31:0] value);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = tag;
    bus.wb_value = value;
  endtask

  initial begin
    int ncom;
    idle();
    rst = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_count",  64'(bus.count), 64'd0);
    check("rst_empty",  64'(bus.empty), 64'd1);
    check("rst_full",   64'(bus.full), 64'd0);
    check("rst_ready",  64'(bus.alloc_ready), 64'd1);
    check("rst_tag",    64'(bus.alloc_tag), 64'd0);
    check("rst_cvalid", 64'(bus.commit_valid), 64'd0);

    // Out-of-order completion, in-order retirement
    rst = 1'b1;
    set_alloc(32'h100, 5'd1, 1'b1); check("ooo_tag0", 64'(bus.alloc_tag), 64'd0); tick();
    set_alloc(32'h104, 5'd2, 1'b1); check("ooo_tag1", 64'(bus.alloc_tag), 64'd1); tick();
    set_alloc(32'h108, 5'd3, 1'b0); check("ooo_tag2", 64'(bus.alloc_tag), 64'd2); tick();
    idle();
    check("ooo_count3", 64'(bus.count), 64'd3);
    set_wb(3'd2, 32'h22); tick();
    check("ooo_nocommit_wb2", 64'(bus.commit_valid), 64'd0);
    set_wb(3'd1, 32'h11); tick();
    check("ooo_nocommit_wb1", 64'(bus.commit_valid), 64'd0);
    set_wb(3'd0, 32'h10); tick();
    idle();
    check("ooo_latency", 64'(bus.commit_valid), 64'd0);
    tick();
    check("ooo_c0_valid", 64'(bus.commit_valid), 64'd1);
    check("ooo_c0_pc",    64'(bus.commit_pc), 64'h100);
    check("ooo_c0_value", 64'(bus.commit_value), 64'h10);
    check("ooo_c0_dest",  64'(bus.commit_dest), 64'd1);
    tick();
    check("ooo_c1_valid", 64'(bus.commit_valid), 64'd1);
    check("ooo_c1_pc",    64'(bus.commit_pc), 64'h104);
    check("ooo_c1_value", 64'(bus.commit_value), 64'h11);
    tick();
    check("ooo_c2_valid", 64'(bus.commit_valid), 64'd1);
    check("ooo_c2_pc",    64'(bus.commit_pc), 64'h108);
    check("ooo_c2_value", 64'(bus.commit_value), 64'h22);
    check("ooo_c2_rw",    64'(bus.commit_regwrite), 64'd0);
    tick();
    check("ooo_done_valid", 64'(bus.commit_valid), 64'd0);
    check("ooo_empty",      64'(bus.empty), 64'd1);

    // Fill to DEPTH starting at tail=3, then an ignored ninth request
    for (int i = 0; i < 8; i++) begin
      set_alloc(32'h200 + 32'(4 * i), 5'(i + 8), 1'b1);
      check($sformatf("fill_tag%0d", i), 64'(bus.alloc_tag), 64'((3 + i) % 8));
      tick();
    end
    check("fill_full",  64'(bus.full), 64'd1);
    check("fill_count", 64'(bus.count), 64'd8);
    check("fill_ready", 64'(bus.alloc_ready), 64'd0);
    set_alloc(32'h300, 5'd31, 1'b1); tick();
    check("fill9_count", 64'(bus.count), 64'd8);
    check("fill9_tag",   64'(bus.alloc_tag), 64'd3);

    // Full ROB: writeback head with a concurrent (rejected) allocation
    set_wb(3'd3, 32'hDEADBEEF); tick();
    bus.wb_valid = 1'b0;
    check("full_wb_count", 64'(bus.count), 64'd8);
    check("full_wb_cv",    64'(bus.commit_valid), 64'd0);
    tick();
    idle();
    check("full_c_valid", 64'(bus.commit_valid), 64'd1);
    check("full_c_value", 64'(bus.commit_value), 64'hDEADBEEF);
    check("full_c_pc",    64'(bus.commit_pc), 64'h200);
    check("full_c_dest",  64'(bus.commit_dest), 64'd8);
    check("full_c_count", 64'(bus.count), 64'd7);
    check("full_c_tag",   64'(bus.alloc_tag), 64'd3);
    check("full_c_ready", 64'(bus.alloc_ready), 64'd1);

    // Flush clears everything
    bus.flush = 1'b1; tick(); idle();
    check("flush1_count", 64'(bus.count), 64'd0);
    check("flush1_empty", 64'(bus.empty), 64'd1);
    check("flush1_tag",   64'(bus.alloc_tag), 64'd0);
    tick();
    check("flush1_cv", 64'(bus.commit_valid), 64'd0);

    // Twelve entries through the wrap: alloc k and complete k-1 each cycle
    ncom = 0;
    for (int k = 0; k < 20; k++) begin
      idle();
      if (k < 12) begin
        set_alloc(32'h400 + 32'(4 * k), 5'(k), 1'b1);
        check($sformatf("wrap_tag%0d", k), 64'(bus.alloc_tag), 64'(k % 8));
      end
      if (k >= 1 && k <= 12) set_wb(3'((k - 1) % 8), 32'h1000 + 32'(k - 1));
      tick();
      if (bus.commit_valid === 1'b1) begin
        check($sformatf("wrap_pc%0d", ncom),    64'(bus.commit_pc), 64'(32'h400 + 32'(4 * ncom)));
        check($sformatf("wrap_value%0d", ncom), 64'(bus.commit_value), 64'(32'h1000 + 32'(ncom)));
        ncom++;
      end
    end
    idle();
    check("wrap_ncommits", 64'(ncom), 64'd12);
    check("wrap_empty",    64'(bus.empty), 64'd1);

    // Flush with partially completed entries; stale writeback afterwards
    bus.flush = 1'b1; tick(); idle();
    for (int i = 0; i < 4; i++) begin
      set_alloc(32'h500 + 32'(4 * i), 5'(i + 1), 1'b1);
      tick();
    end
    idle();
    set_wb(3'd1, 32'h51); tick();
    set_wb(3'd3, 32'h53); tick();
    idle();
    check("fl_pre_count", 64'(bus.count), 64'd4);
    check("fl_pre_cv",    64'(bus.commit_valid), 64'd0);
    bus.flush = 1'b1; tick(); idle();
    check("fl_count", 64'(bus.count), 64'd0);
    check("fl_cv",    64'(bus.commit_valid), 64'd0);
    set_wb(3'd1, 32'h55); tick(); idle();
    check("fl_stale_count", 64'(bus.count), 64'd0);
    check("fl_stale_cv",    64'(bus.commit_valid), 64'd0);
    check("fl_next_tag",    64'(bus.alloc_tag), 64'd0);
    set_alloc(32'h580, 5'd9, 1'b1); tick(); idle();
    check("fl_alloc_count", 64'(bus.count), 64'd1);
    tick();
    check("fl_head_not_done", 64'(bus.commit_valid), 64'd0);
    set_wb(3'd0, 32'h77); tick(); idle();
    tick();
    check("fl_c_valid", 64'(bus.commit_valid), 64'd1);
    check("fl_c_pc",    64'(bus.commit_pc), 64'h580);
    check("fl_c_value", 64'(bus.commit_value), 64'h77);

    // Reset mid-operation with a completed head: no retire pulse
    set_alloc(32'h600, 5'd17, 1'b1); tick(); idle();
    set_wb(3'd1, 32'hAA); tick(); idle();
    rst = 1'b0;
    bus.flush = 1'b1;
    set_alloc(32'h700, 5'd5, 1'b1);
    tick();
    idle();
    check("rst2_cv",    64'(bus.commit_valid), 64'd0);
    check("rst2_rw",    64'(bus.commit_regwrite), 64'd0);
    check("rst2_dest",  64'(bus.commit_dest), 64'd0);
    check("rst2_value", 64'(bus.commit_value), 64'd0);
    check("rst2_pc",    64'(bus.commit_pc), 64'd0);
    check("rst2_count", 64'(bus.count), 64'd0);
    check("rst2_empty", 64'(bus.empty), 64'd1);
    check("rst2_tag",   64'(bus.alloc_tag), 64'd0);
    rst = 1'b1;
    tick();
    check("rst2_after_cv", 64'(bus.commit_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
